// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and constants for the LEGv8 phase sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_pkg;

    // Sequencer states; the five datapath phases plus idle, stretch and fault
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        MEM_WAIT  = 3'd5,
        WRITEBACK = 3'd6,
        ERROR     = 3'd7
    } seq_state_t;

    // Cycles taken by an instruction that never stalls in memory
    localparam int NUM_PHASES = 5;

endpackage
`default_nettype wire

// File: rtl/phase_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer_if
//  Description : Control/status bundle between the sequencer and its host.
//  Revision    : 1.0  initial release
// ============================================================================
interface phase_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic             halt_req;
    logic             clr_counters;
    logic             mem_access;
    logic             mem_ready;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pc_en;
    logic             busy;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    // Host side: drives control, observes phase enables and status
    modport master (
        output run, step, halt_req, clr_counters, mem_access, mem_ready,
        input  fetch_en, decode_en, execute_en, memory_en, writeback_en,
        input  pc_en, busy, halted, timeout_err, cycle_count, instr_count
    );

    // Sequencer side
    modport slave (
        input  run, step, halt_req, clr_counters, mem_access, mem_ready,
        output fetch_en, decode_en, execute_en, memory_en, writeback_en,
        output pc_en, busy, halted, timeout_err, cycle_count, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; clear beats increment.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clr,
    input  wire logic         i_inc,
    output logic      [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Count with saturation; synchronous clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sequencer
//  Description : Per-phase enable sequencer for the non-pipelined LEGv8
//                datapath with memory-stall stretching, run/step/halt
//                control and saturating cycle / retired-instruction counters.
//  Revision    : 1.0  initial release
// ============================================================================
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    phase_sequencer_if.slave  bus
);
    // A zero timeout still needs a one-bit counter to keep widths legal
    localparam int              c_WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit              c_TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic                r_halt_pend;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_fetch_en, r_decode_en, r_execute_en, r_memory_en;
    logic                r_writeback_en, r_busy, r_halted, r_timeout_err;
    logic [CNT_W-1:0]    w_cycle_count, w_instr_count;

    // Next-state decision from the current state and sampled controls
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.run) begin
                    w_next = bus.halt_req ? IDLE : FETCH;
                end else if (bus.step) begin
                    w_next = FETCH;
                end
            end
            FETCH:     w_next = DECODE;
            DECODE:    w_next = EXECUTE;
            EXECUTE:   w_next = MEMORY;
            MEMORY: begin
                if (!bus.mem_access || bus.mem_ready) begin
                    w_next = WRITEBACK;
                end else begin
                    w_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    w_next = WRITEBACK;
                end else if (c_TO_EN && (r_wait == c_TIMEOUT)) begin
                    w_next = ERROR;
                end
            end
            WRITEBACK: w_next = (bus.run && !r_halt_pend) ? FETCH : IDLE;
            ERROR:     w_next = ERROR;
            default:   w_next = IDLE;
        endcase
    end

    // State register with Moore outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_fetch_en     <= 1'b0;
            r_decode_en    <= 1'b0;
            r_execute_en   <= 1'b0;
            r_memory_en    <= 1'b0;
            r_writeback_en <= 1'b0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b1;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_fetch_en     <= (w_next == FETCH);
            r_decode_en    <= (w_next == DECODE);
            r_execute_en   <= (w_next == EXECUTE);
            r_memory_en    <= (w_next == MEMORY) || (w_next == MEM_WAIT);
            r_writeback_en <= (w_next == WRITEBACK);
            r_busy         <= (w_next != IDLE) && (w_next != ERROR);
            r_halted       <= (w_next == IDLE);
            r_timeout_err  <= (w_next == ERROR);
        end
    end

    // Remember a halt request until the sequencer parks in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halt_pend <= 1'b0;
        end else if (w_next == IDLE) begin
            r_halt_pend <= 1'b0;
        end else if (bus.halt_req && r_busy) begin
            r_halt_pend <= 1'b1;
        end
    end

    // Count stall cycles; saturates so a long stall never reads as fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if ((r_state == MEMORY) && (w_next == MEM_WAIT)) begin
            r_wait <= c_WAIT_W'(1);
        end else if ((r_state == MEM_WAIT) && (w_next == MEM_WAIT) &&
                     (r_wait != {c_WAIT_W{1'b1}})) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (bus.clr_counters),
        .i_inc (r_busy),
        .o_q   (w_cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (bus.clr_counters),
        .i_inc (r_writeback_en),
        .o_q   (w_instr_count)
    );

    assign bus.fetch_en     = r_fetch_en;
    assign bus.decode_en    = r_decode_en;
    assign bus.execute_en   = r_execute_en;
    assign bus.memory_en    = r_memory_en;
    assign bus.writeback_en = r_writeback_en;
    assign bus.pc_en        = r_writeback_en;
    assign bus.busy         = r_busy;
    assign bus.halted       = r_halted;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.cycle_count  = w_cycle_count;
    assign bus.instr_count  = w_instr_count;
endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Scoreboard bench for phase_sequencer. Instance A (32-bit
//                counters, timeout 4) carries retirement checks; instance B
//                (4-bit counters, timeout disabled) covers saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phase_sequencer;
    import seq_pkg::*;

    typedef struct {
        int lat;
        int mem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   tests = 0;
    int   failed = 0;
    exp_t q[$];

    phase_sequencer_if #(.CNT_W(32)) ifa ();
    phase_sequencer_if #(.CNT_W(4))  ifb ();

    phase_sequencer #(.CNT_W(32), .MEM_TIMEOUT(4)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    phase_sequencer #(.CNT_W(4), .MEM_TIMEOUT(0)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int waits);
        exp_t e;
        e.lat = NUM_PHASES + waits;
        e.mem = 1 + waits;
        q.push_back(e);
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        while (!ifa.halted && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, ifa.halted, 1'b1);
    endtask

    task automatic wait_idle_b(input string name);
        int n;
        n = 0;
        while (!ifb.halted && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, ifb.halted, 1'b1);
    endtask

    // Monitor: measure each instruction on A and compare at retirement
    initial begin : monitor
        int   lat;
        int   mem;
        bit   inflight;
        exp_t e;
        lat = 0;
        mem = 0;
        inflight = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                inflight = 1'b0;
            end else begin
                if (ifa.fetch_en) begin
                    inflight = 1'b1;
                    lat = 0;
                    mem = 0;
                end
                if (inflight) begin
                    lat++;
                    if (ifa.memory_en) mem++;
                end
                if (ifa.writeback_en) begin
                    tests++;
                    if (q.size() == 0) begin
                        failed++;
                        $display("FAIL retire_unexpected: got retirement lat=%0d expected none", lat);
                    end else begin
                        e = q.pop_front();
                        if (lat != e.lat || mem != e.mem || !ifa.pc_en || !inflight) begin
                            failed++;
                            $display("FAIL retire: got lat=%0d mem=%0d pc_en=%0b expected lat=%0d mem=%0d pc_en=1",
                                     lat, mem, ifa.pc_en, e.lat, e.mem);
                        end
                    end
                    inflight = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        {ifa.run, ifa.step, ifa.halt_req, ifa.clr_counters, ifa.mem_access, ifa.mem_ready} = '0;
        {ifb.run, ifb.step, ifb.halt_req, ifb.clr_counters, ifb.mem_access, ifb.mem_ready} = '0;

        // T1: reset state, then free-run without memory access
        tick(2);
        chk("reset_outputs",
            {ifa.fetch_en, ifa.decode_en, ifa.execute_en, ifa.memory_en, ifa.writeback_en,
             ifa.pc_en, ifa.busy, ifa.timeout_err, ifa.halted}, 9'b000000001);
        chk("reset_counts", {ifa.cycle_count, ifa.instr_count}, 64'd0);
        rst_a = 1'b0;
        ifa.run = 1'b1;
        repeat (5) push(0);
        tick(21);
        chk("t1_cycle_count", ifa.cycle_count, 64'd20);
        chk("t1_instr_count", ifa.instr_count, 64'd4);
        ifa.run = 1'b0;
        wait_idle_a("t1_idle");
        chk("t1_final_counts", {ifa.cycle_count, ifa.instr_count}, {32'd25, 32'd5});

        // Counter clear
        ifa.clr_counters = 1'b1;
        tick(1);
        ifa.clr_counters = 1'b0;
        chk("clr_counters", {ifa.cycle_count, ifa.instr_count}, 64'd0);

        // T2: single step; a second step in DECODE is ignored
        ifa.step = 1'b1;
        push(0);
        tick(1);
        ifa.step = 1'b0;
        tick(1);
        chk("t2_decode", ifa.decode_en, 1'b1);
        ifa.step = 1'b1;
        tick(1);
        ifa.step = 1'b0;
        wait_idle_a("t2_idle");
        tick(3);
        chk("t2_one_shot", {ifa.halted, ifa.busy, ifa.pc_en, ifa.instr_count}, {3'b100, 32'd1});

        // T3: halt request during EXECUTE of the third instruction
        ifa.clr_counters = 1'b1;
        tick(1);
        ifa.clr_counters = 1'b0;
        ifa.run = 1'b1;
        repeat (3) push(0);
        tick(13);
        chk("t3_execute", ifa.execute_en, 1'b1);
        ifa.halt_req = 1'b1;
        tick(1);
        ifa.halt_req = 1'b0;
        wait_idle_a("t3_idle");
        ifa.run = 1'b0;
        chk("t3_instr_count", ifa.instr_count, 64'd3);

        // halt_req held in IDLE with run=1 keeps the sequencer parked
        ifa.run = 1'b1;
        ifa.halt_req = 1'b1;
        tick(3);
        chk("halt_blocks_start", {ifa.halted, ifa.busy}, 2'b10);
        ifa.run = 1'b0;
        ifa.halt_req = 1'b0;

        // T4: memory stall of three cycles, then ready in MEMORY
        ifa.mem_access = 1'b1;
        ifa.step = 1'b1;
        push(3);
        tick(1);
        ifa.step = 1'b0;
        tick(6);
        ifa.mem_ready = 1'b1;
        wait_idle_a("t4_stall_idle");
        ifa.step = 1'b1;
        push(0);
        tick(1);
        ifa.step = 1'b0;
        wait_idle_a("t4_ready_idle");
        ifa.mem_ready = 1'b0;

        // T5: ready on the last permitted wait cycle still retires
        ifa.step = 1'b1;
        push(4);
        tick(1);
        ifa.step = 1'b0;
        tick(7);
        ifa.mem_ready = 1'b1;
        wait_idle_a("t5_ready_idle");
        ifa.mem_ready = 1'b0;

        // T5: no ready -> ERROR after four wait cycles, sticky
        ifa.step = 1'b1;
        tick(1);
        ifa.step = 1'b0;
        tick(7);
        chk("t5_last_wait", {ifa.memory_en, ifa.timeout_err}, 2'b10);
        tick(1);
        chk("t5_error",
            {ifa.fetch_en, ifa.decode_en, ifa.execute_en, ifa.memory_en, ifa.writeback_en,
             ifa.pc_en, ifa.busy, ifa.timeout_err, ifa.halted}, 9'b000000010);
        ifa.run = 1'b1;
        tick(3);
        chk("t5_run_ignored", {ifa.timeout_err, ifa.fetch_en, ifa.busy}, 3'b100);
        ifa.run = 1'b0;
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        chk("t5_reset_clears", {ifa.timeout_err, ifa.halted}, 2'b01);

        // T6: asynchronous reset while stalled in MEM_WAIT
        ifa.step = 1'b1;
        tick(1);
        ifa.step = 1'b0;
        tick(4);
        chk("t6_in_wait", {ifa.memory_en, ifa.busy}, 2'b11);
        #2;
        rst_a = 1'b1;
        #1;
        chk("t6_async_reset", {ifa.halted, ifa.busy, ifa.memory_en, ifa.pc_en}, 4'b1000);
        tick(2);
        rst_a = 1'b0;
        ifa.mem_access = 1'b0;

        // T6: 4-bit counters saturate, clear wins over increment
        rst_b = 1'b0;
        ifb.run = 1'b1;
        tick(20);
        chk("t6_cycle_sat", ifb.cycle_count, 64'd15);
        chk("t6_instr_count", ifb.instr_count, 64'd3);
        ifb.clr_counters = 1'b1;
        tick(1);
        ifb.clr_counters = 1'b0;
        chk("t6_clr", {ifb.cycle_count, ifb.instr_count}, 8'h00);
        tick(1);
        chk("t6_after_clr", ifb.cycle_count, 64'd1);
        ifb.run = 1'b0;
        wait_idle_b("t6_b_idle");

        // Timeout disabled: a long stall never reaches ERROR
        ifb.mem_access = 1'b1;
        ifb.step = 1'b1;
        tick(1);
        ifb.step = 1'b0;
        tick(30);
        chk("no_timeout", {ifb.memory_en, ifb.busy, ifb.timeout_err}, 3'b110);
        ifb.mem_ready = 1'b1;
        wait_idle_b("no_timeout_idle");

        tick(2);
        chk("scoreboard_drained", q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
`default_nettype wire
